arm_bus_responder: RTL

- Target end of the single-cycle ARM core's data-memory interface: accepts the core's data address, write data, write strobe and chip select, and returns read data in the same cycle.
- Contains a word-addressed data RAM and a memory-mapped I/O page.
- The I/O page holds a compare timer with interrupt and a byte output FIFO drained over a valid/ready handshake.
- Sits beside the core at the top level, replacing a plain data memory.

---
 rtl/arm_bus_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/arm_bus_responder.sv
// Data-side responder for the single-cycle ARM core: word RAM plus an I/O page
// with a compare timer (level irq) and a byte output FIFO drained by valid/ready.
module arm_bus_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [2:0] SEL_CNT   = 3'd0;
  localparam logic [2:0] SEL_CMP   = 3'd1;
  localparam logic [2:0] SEL_STAT  = 3'd2;
  localparam logic [2:0] SEL_FDATA = 3'd3;
  localparam logic [2:0] SEL_FSTAT = 3'd4;

  logic [31:0] io_off;
  logic        ram_hit, io_hit, wr_en;
  logic [2:0]  io_sel;
  logic [AW-1:0] ram_idx;

  logic [31:0] ram_q [RAM_WORDS];

  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic        match_q, match_d, en_q, en_d, irq_en_q, irq_en_d;
  logic        timer_hit;

  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [FW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FW:0]   count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        full, empty, pop, push_req, push_ok;

  assign io_off  = ALUResult - IO_BASE;
  assign ram_hit = ALUResult < RAM_BYTES;
  assign io_hit  = (ALUResult >= IO_BASE) && (io_off < 32'h14);
  assign io_sel  = io_off[4:2];
  assign ram_idx = ALUResult[AW+1:2];
  assign wr_en   = cs & MemWrite;

  // Timer: a CPU write to CNT beats increment/wrap, but the match still flags.
  assign timer_hit = en_q && (cnt_q == cmp_q);

  always_comb begin
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    match_d  = match_q;
    if (en_q) cnt_d = timer_hit ? 32'd0 : cnt_q + 32'd1;
    if (wr_en && io_hit && io_sel == SEL_CNT) cnt_d = WriteData;
    if (wr_en && io_hit && io_sel == SEL_CMP) cmp_d = WriteData;
    if (wr_en && io_hit && io_sel == SEL_STAT) begin
      en_d     = WriteData[1];
      irq_en_d = WriteData[2];
      if (WriteData[0]) match_d = 1'b0;
    end
    if (timer_hit) match_d = 1'b1;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == (FW+1)'(FIFO_DEPTH));
  assign pop      = out_valid & out_ready;
  assign push_req = wr_en & io_hit & (io_sel == SEL_FDATA);
  // A pop frees the slot in the same edge, so a push into a full FIFO survives.
  assign push_ok  = push_req & (~full | pop);

  always_comb begin
    wptr_d  = push_ok ? wptr_q + FW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + FW'(1) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FW+1)'(1);
      2'b01:   count_d = count_q - (FW+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_en && io_hit && io_sel == SEL_FSTAT && WriteData[16]) ovf_d = 1'b0;
    if (push_req & full & ~pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      match_q  <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset; only the pointers define FIFO contents.
  always_ff @(posedge clk) begin
    if (reset && wr_en && ram_hit) ram_q[ram_idx] <= WriteData;
    if (reset && push_ok) fifo_q[wptr_q] <= WriteData[7:0];
  end

  assign out_valid = ~empty;
  assign out_data  = fifo_q[rptr_q];
  assign irq       = match_q & irq_en_q;

  always_comb begin
    ReadData = 32'd0;
    if (cs && ram_hit) begin
      ReadData = ram_q[ram_idx];
    end else if (cs && io_hit) begin
      case (io_sel)
        SEL_CNT:   ReadData = cnt_q;
        SEL_CMP:   ReadData = cmp_q;
        SEL_STAT:  ReadData = {29'd0, irq_en_q, en_q, match_q};
        SEL_FSTAT: ReadData = {15'd0, ovf_q, 6'd0, full, empty, 8'(count_q)};
        default:   ReadData = 32'd0;
      endcase
    end
  end

endmodule
